beat_tone_player: RTL and testbench

Downstream consumer of the beat detector's outputs: turns each detected beat (`beat_en` plus 2-bit `beat_intensity`) into an audible square-wave tone burst on a single speaker pin. Burst length and loudness depend on intensity. Loudness is set by PWM duty gating the tone.
- Runs on the 50 MHz system clock.
- Its beat inputs come from the 10 ms scaled-clock domain, so it synchronizes them internally.
- Sits between the beat generator and the board's piezo/speaker pin.

---
 rtl/beat_tone_pkg.sv | 14 +
 rtl/beat_tone_player_sync.sv | 31 +++
 rtl/beat_tone_player.sv | 111 +++++++++++
 tb/tb_beat_tone_player.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/beat_tone_pkg.sv
// rtl/beat_tone_pkg.sv - shared states and intensity lookup tables for the beat tone player
package beat_tone_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Indexed by the 2-bit beat intensity.
    localparam logic [7:0] DUTY   [4] = '{8'd64, 8'd128, 8'd192, 8'd255};
    localparam logic [7:0] DUR_MS [4] = '{8'd25, 8'd50, 8'd100, 8'd200};

endpackage

// File: rtl/beat_tone_player_sync.sv
// rtl/beat_tone_player_sync.sv - two-flop synchronizer with rising-edge detect on the MSB strobe
module beat_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-2:0] q,
    output logic             rise
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            last <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            last <= s2[WIDTH-1];
        end
    end

    assign q    = s2[WIDTH-2:0];
    assign rise = s2[WIDTH-1] & ~last;

endmodule

// File: rtl/beat_tone_player.sv
// rtl/beat_tone_player.sv - turns synchronized beats into intensity-shaped, PWM-gated tone bursts
module beat_tone_player
    import beat_tone_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int TONE_HALF = 56818,
    parameter int GAP_MS    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       beat_en,
    input  logic [1:0] beat_intensity,
    output logic       spk_out,
    output logic       busy,
    output logic [7:0] dropped_cnt
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    logic [1:0]    sync_int;
    logic          beat_rise;
    state_t        state;
    state_t        state_next;
    logic [1:0]    int_q;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    ms_cnt;
    logic [HW-1:0] tone_cnt;
    logic          tone_ph;
    logic [7:0]    pwm_cnt;
    logic          tick;
    logic          restart;
    logic          enter;
    logic          pwm_on;

    beat_sync #(.WIDTH(3)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({beat_en, beat_intensity}),
        .q    (sync_int),
        .rise (beat_rise)
    );

    assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
    assign restart = (state == PLAY) && beat_rise;
    assign enter   = (state_next != state) || restart;
    assign pwm_on  = (pwm_cnt < DUTY[int_q]);
    assign busy    = (state != IDLE);

    // Expiry compares against target-1 so the transition lands on the tick that reaches it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (beat_rise) state_next = PLAY;
            PLAY: if (!beat_rise && tick && ms_cnt == DUR_MS[int_q] - 8'd1) state_next = GAP;
            GAP:  if (tick && ms_cnt == 8'(GAP_MS - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            int_q       <= 2'd0;
            tick_cnt    <= '0;
            ms_cnt      <= 8'd0;
            tone_cnt    <= '0;
            tone_ph     <= 1'b0;
            pwm_cnt     <= 8'd0;
            dropped_cnt <= 8'd0;
            spk_out     <= 1'b0;
        end else begin
            state <= state_next;

            if (enter) begin
                tick_cnt <= '0;
                ms_cnt   <= 8'd0;
            end else if (state != IDLE) begin
                if (tick) begin
                    tick_cnt <= '0;
                    ms_cnt   <= ms_cnt + 8'd1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end

            if (beat_rise && state != GAP) int_q <= sync_int;

            if (enter && state_next == PLAY) begin
                tone_cnt <= '0;
                tone_ph  <= 1'b1;
                pwm_cnt  <= 8'd0;
            end else if (state == PLAY) begin
                pwm_cnt <= pwm_cnt + 8'd1;
                if (tone_cnt == HW'(TONE_HALF - 1)) begin
                    tone_cnt <= '0;
                    tone_ph  <= ~tone_ph;
                end else begin
                    tone_cnt <= tone_cnt + HW'(1);
                end
            end

            if (state == GAP && beat_rise && dropped_cnt != 8'hFF)
                dropped_cnt <= dropped_cnt + 8'd1;

            // Also gated by the next state so the pin is silent from the first GAP cycle.
            spk_out <= tone_ph && pwm_on && (state == PLAY) && (state_next == PLAY);
        end
    end

endmodule

// File: tb/tb_beat_tone_player.sv
// tb/tb_beat_tone_player.sv - directed self-checking bench for beat_tone_player
module tb_beat_tone_player;
    import beat_tone_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       beat_en = 1'b0;
    logic [1:0] beat_intensity = 2'd0;
    logic       spk_out;
    logic       busy;
    logic [7:0] dropped_cnt;
    logic       en2 = 1'b0;
    logic [1:0] int2 = 2'd0;
    logic       spk2;
    logic       busy2;
    logic [7:0] dropped2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    beat_tone_player #(.TICK_DIV(10), .TONE_HALF(4), .GAP_MS(2)) dut (
        .clk(clk), .rst_n(rst_n), .beat_en(beat_en), .beat_intensity(beat_intensity),
        .spk_out(spk_out), .busy(busy), .dropped_cnt(dropped_cnt)
    );

    beat_tone_player #(.TICK_DIV(10), .TONE_HALF(4), .GAP_MS(255)) dut2 (
        .clk(clk), .rst_n(rst_n), .beat_en(en2), .beat_intensity(int2),
        .spk_out(spk2), .busy(busy2), .dropped_cnt(dropped2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Raises beat_en; returns at the sample after the second edge that saw it high.
    task automatic fire(input logic [1:0] i);
        beat_intensity = i;
        beat_en = 1'b1;
        cyc();
        cyc();
    endtask

    // Starts at the sample just after PLAY entry; checks spk against a tone*PWM envelope model.
    task automatic play_monitor(input int duty, input int hold, input int maxc,
                                output int len, output int bad, output int cnt256);
        int  j;
        logic exp;
        len = 0;
        bad = 0;
        cnt256 = 0;
        for (int t = 1; t <= maxc; t++) begin
            cyc();
            if (t == hold) beat_en = 1'b0;
            if (dut.state != PLAY) begin
                len = t;
                break;
            end
            j = t - 1;
            exp = (((j / 4) % 2) == 0) && ((j % 256) < duty);
            if (spk_out !== exp) bad++;
            if (t <= 256 && spk_out === 1'b1) cnt256++;
        end
    endtask

    task automatic gap_monitor(input int maxc, output int len, output int hi);
        len = 0;
        hi = (spk_out !== 1'b0) ? 1 : 0;
        for (int t = 1; t <= maxc; t++) begin
            cyc();
            if (dut.state == IDLE) begin
                len = t;
                break;
            end
            if (spk_out !== 1'b0) hi++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        checks++; if (spk_out !== 1'b0) begin errors++; $display("FAIL reset_spk: got %b expected 0", spk_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dropped_cnt !== 8'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped_cnt); end
        checks++; if (dropped2 !== 8'd0) begin errors++; $display("FAIL reset_dropped2: got %0d expected 0", dropped2); end
        rst_n = 1'b1;
        repeat (3) cyc();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    endtask

    task automatic test_single();
        int len, bad, c, glen, ghi, bcnt;
        fire(2'd2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_early: got %b expected 0", busy); end
        cyc();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b expected 1", busy); end
        checks++; if (spk_out !== 1'b0) begin errors++; $display("FAIL single_spk_entry: got %b expected 0", spk_out); end
        play_monitor(192, 46, 1500, len, bad, c);
        checks++; if (len != 1000) begin errors++; $display("FAIL single_play_len: got %0d expected 1000", len); end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_envelope: got %0d bad cycles expected 0", bad); end
        checks++; if (c != 96) begin errors++; $display("FAIL single_duty: got %0d high expected 96", c); end
        gap_monitor(100, glen, ghi);
        checks++; if (glen != 20) begin errors++; $display("FAIL single_gap_len: got %0d expected 20", glen); end
        checks++; if (ghi != 0) begin errors++; $display("FAIL single_gap_spk: got %0d high expected 0", ghi); end
        bcnt = 0;
        repeat (100) begin cyc(); if (busy !== 1'b0) bcnt++; end
        checks++; if (bcnt != 0) begin errors++; $display("FAIL single_one_burst: got %0d busy cycles expected 0", bcnt); end
    endtask

    task automatic test_intensity();
        int len, bad, c, glen, ghi;
        fire(2'd0);
        cyc();
        play_monitor(64, 1, 500, len, bad, c);
        checks++; if (len != 250) begin errors++; $display("FAIL int0_len: got %0d expected 250", len); end
        checks++; if (bad != 0) begin errors++; $display("FAIL int0_envelope: got %0d expected 0", bad); end
        checks++; if (c != 32) begin errors++; $display("FAIL int0_duty: got %0d expected 32", c); end
        gap_monitor(100, glen, ghi);
        checks++; if (glen != 20) begin errors++; $display("FAIL int0_gap: got %0d expected 20", glen); end
        repeat (5) cyc();
        fire(2'd3);
        cyc();
        play_monitor(255, 1, 2500, len, bad, c);
        checks++; if (len != 2000) begin errors++; $display("FAIL int3_len: got %0d expected 2000", len); end
        checks++; if (bad != 0) begin errors++; $display("FAIL int3_envelope: got %0d expected 0", bad); end
        checks++; if (c != 128) begin errors++; $display("FAIL int3_duty: got %0d expected 128", c); end
        gap_monitor(100, glen, ghi);
        checks++; if (glen != 20) begin errors++; $display("FAIL int3_gap: got %0d expected 20", glen); end
        repeat (5) cyc();
    endtask

    task automatic test_retrigger();
        int len, bad, c, glen, ghi;
        fire(2'd1);
        cyc();
        beat_en = 1'b0;
        repeat (297) cyc();
        fire(2'd3);
        cyc();
        checks++; if (dut.state !== PLAY) begin errors++; $display("FAIL retrig_state: got %0d expected %0d", dut.state, PLAY); end
        play_monitor(255, 1, 2500, len, bad, c);
        checks++; if (len != 2000) begin errors++; $display("FAIL retrig_len: got %0d expected 2000", len); end
        checks++; if (bad != 0) begin errors++; $display("FAIL retrig_envelope: got %0d expected 0", bad); end
        gap_monitor(100, glen, ghi);
        checks++; if (dropped_cnt !== 8'd0) begin errors++; $display("FAIL retrig_dropped: got %0d expected 0", dropped_cnt); end
        repeat (5) cyc();
    endtask

    task automatic test_boundary();
        int len, bad, c, bcnt;
        fire(2'd0);
        cyc();
        beat_en = 1'b0;
        repeat (247) cyc();
        fire(2'd1);
        cyc();
        checks++; if (dut.state !== PLAY) begin errors++; $display("FAIL bound_play_restart: got %0d expected %0d", dut.state, PLAY); end
        play_monitor(128, 1, 1000, len, bad, c);
        checks++; if (len != 500) begin errors++; $display("FAIL bound_play_len: got %0d expected 500", len); end
        checks++; if (bad != 0) begin errors++; $display("FAIL bound_envelope: got %0d expected 0", bad); end
        repeat (17) cyc();
        fire(2'd2);
        cyc();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL bound_gap_state: got %0d expected %0d", dut.state, IDLE); end
        checks++; if (dropped_cnt !== 8'd1) begin errors++; $display("FAIL bound_gap_dropped: got %0d expected 1", dropped_cnt); end
        bcnt = 0;
        repeat (10) begin cyc(); if (busy !== 1'b0) bcnt++; end
        checks++; if (bcnt != 0) begin errors++; $display("FAIL bound_held_level: got %0d busy cycles expected 0", bcnt); end
        beat_en = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_drops();
        int n;
        int2 = 2'd0;
        en2 = 1'b1;
        cyc();
        cyc();
        en2 = 1'b0;
        n = 2;
        while (dut2.state != GAP && n < 400) begin cyc(); n++; end
        checks++; if (n != 253) begin errors++; $display("FAIL drops_gap_entry: got %0d expected 253", n); end
        for (int b = 0; b < 300; b++) begin
            en2 = 1'b1;
            cyc();
            cyc();
            en2 = 1'b0;
            cyc();
            cyc();
            if (b == 99) begin
                checks++; if (dropped2 !== 8'd100) begin errors++; $display("FAIL drops_count100: got %0d expected 100", dropped2); end
            end
        end
        cyc();
        checks++; if (dropped2 !== 8'd255) begin errors++; $display("FAIL drops_saturate: got %0d expected 255", dropped2); end
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL drops_still_gap: got %b expected 1", busy2); end
    endtask

    task automatic test_async_reset();
        fire(2'd3);
        cyc();
        cyc();
        checks++; if (spk_out !== 1'b1) begin errors++; $display("FAIL areset_pre_spk: got %b expected 1", spk_out); end
        beat_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (spk_out !== 1'b0) begin errors++; $display("FAIL areset_spk: got %b expected 0", spk_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b expected 0", busy); end
        checks++; if (dropped_cnt !== 8'd0) begin errors++; $display("FAIL areset_dropped: got %0d expected 0", dropped_cnt); end
        checks++; if (dropped2 !== 8'd0) begin errors++; $display("FAIL areset_dropped2: got %0d expected 0", dropped2); end
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL areset_state: got %0d expected %0d", dut.state, IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy_after: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_intensity();
        test_retrigger();
        test_boundary();
        test_drops();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
